stock_manager: RTL
==================

// Module: stock_manager
// PURPOSE
//  Holds per-item inventory for the four vend items. Sits directly downstream of the vending
//  state machine: consumes its item_code and decrement outputs, and returns the cs_pc/cs_cb/cs_s/cs_c
//  stock counts that it uses for out-of-stock checks. Also accepts operator restock requests.
// PARAMETERS
//  CNT_W       3    width of each stock counter
//  MAX_STOCK   7    saturation ceiling for restock; must be <= 2**CNT_W-1
//  INIT_STOCK  5    count loaded into every slot on reset
//  LOW_THRESH  1    low_stock[i]=1 when count<=LOW_THRESH
// PORTS
//  clk            in   1      system clock, all logic on posedge
//  reset          in   1      asynchronous, active-low reset
//  item_code      in   8      selected item code (A2/B3/D5/E8) from vending FSM
//  decrement      in   1      vend-complete strobe from vending FSM (combinational at source)
//  restock_req    in   1      restock request, held high until restock_ack seen
//  restock_code   in   8      item code to restock, stable while restock_req=1
//  restock_qty    in   CNT_W  units to add
//  restock_ack    out  1      one-cycle pulse: restock applied
//  cs_pc          out  CNT_W  potato_chips stock count
//  cs_cb          out  CNT_W  candy_bar stock count
//  cs_s           out  CNT_W  soda stock count
//  cs_c           out  CNT_W  cookie stock count
//  low_stock      out  4      {cookie,soda,candy_bar,potato_chips} at/below LOW_THRESH
//  err            out  1      sticky: underflow vend or unknown code; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release): all counts=INIT_STOCK, restock_ack=0, err=0, FSM R_IDLE,
//   dec_q=0. low_stock derives from counts (0 at reset with defaults).
//  Vend: dec_q registers decrement. vend_ev = decrement & ~dec_q (rising edge; a strobe held
//   several cycles counts once). On vend_ev, slot chosen by item_code decrements at the same edge;
//   cs_* reflect new value on the following cycle (1-cycle latency).
//  Vend on count 0: count stays 0, err<=1. Vend with unknown item_code: no count change, err<=1.
//  Restock FSM (one-hot-free binary enum in package):
//   R_IDLE : restock_req=1 -> latch code/qty, -> R_APPLY
//   R_APPLY: slot += qty, saturating at MAX_STOCK; unknown code -> err<=1, no change; -> R_ACK
//   R_ACK  : restock_ack=1 for exactly this cycle; -> R_WAIT
//   R_WAIT : restock_req=0 -> R_IDLE; holds while req stays high (no double apply)
//  Arithmetic: CNT_W+1 bit intermediate; result = min(count - v + qty, MAX_STOCK), floored at 0.
//  Simultaneous vend_ev and R_APPLY on the same slot: both applied in one update via the formula
//   above (vend first, then add). Different slots: independent, both applied.
//  restock_qty=0: FSM still completes with ack, count unchanged.
//  Reset mid-restock: FSM returns R_IDLE, no ack issued; requester must re-request.
//  low_stock combinational from registered counts.
// CONFIGURATION
//  SALES_COUNT_EN defined: adds outputs sales_total [7:0] and per-slot 8-bit sold counters
//   (internal), incremented on each successful vend (not on underflow/unknown), wrapping 255->0;
//   sales_total = wrapping 8-bit count of all successful vends, reset to 0.
//  SALES_COUNT_EN undefined: no sales logic or port; all other behaviour identical.
// STRUCTURE
//  vend_pkg: item code constants (A2,B3,D5,E8), prices, item index enum, restock FSM enum,
//   code->index decode function returning valid flag.
//  Sub-module stock_slot (x4): one counter with dec, add_en, add_qty inputs, saturating/floor
//   update, underflow flag output. Top holds edge detect, decode, restock FSM, err, outputs.
// TESTING
//  Reset -> cs_pc=cs_cb=cs_s=cs_c=5, low_stock=0, err=0, restock_ack=0.
//  item_code=D5, decrement high 3 cycles -> cs_s 5->4 once, one cycle after first high edge.
//  6 vends of E8 from 5 -> cs_c reaches 0 after 5, low_stock[3]=1 at 1; 6th: cs_c=0, err=1.
//  restock_req B3 qty=6 with cs_cb=5 -> cs_cb=7 (saturated), ack one cycle, no re-apply while
//   req held; drop req -> R_IDLE.
//  Vend A2 on same edge as R_APPLY A2 qty=2, cs_pc=5 -> cs_pc=6; unknown code 8'h11 restock -> err=1.
//  SALES_COUNT_EN: 3 successful vends + 1 underflow -> sales_total=3; 256 vends -> wraps to 0.

Source files
------------

// File: rtl/stock_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module : stock_manager_pkg
// Brief  : Item codes, prices, slot index and restock FSM types, code decoder.
// Rev    : 1.0  initial release
// ============================================================================
package stock_manager_pkg;

    localparam logic [7:0] CODE_A2 = 8'hA2;
    localparam logic [7:0] CODE_B3 = 8'hB3;
    localparam logic [7:0] CODE_D5 = 8'hD5;
    localparam logic [7:0] CODE_E8 = 8'hE8;

    localparam logic [7:0] PRICE_PC = 8'd25;
    localparam logic [7:0] PRICE_CB = 8'd35;
    localparam logic [7:0] PRICE_S  = 8'd45;
    localparam logic [7:0] PRICE_C  = 8'd30;

    localparam int NUM_ITEMS = 4;

    typedef enum logic [1:0] {
        IDX_PC = 2'd0,
        IDX_CB = 2'd1,
        IDX_S  = 2'd2,
        IDX_C  = 2'd3
    } item_idx_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_APPLY = 2'd1,
        R_ACK   = 2'd2,
        R_WAIT  = 2'd3
    } r_state_t;

    typedef struct packed {
        logic      valid;
        item_idx_t idx;
    } item_dec_t;

    function automatic item_dec_t decode_item(input logic [7:0] code);
        item_dec_t d;
        d.valid = 1'b1;
        d.idx   = IDX_PC;
        case (code)
            CODE_A2: d.idx = IDX_PC;
            CODE_B3: d.idx = IDX_CB;
            CODE_D5: d.idx = IDX_S;
            CODE_E8: d.idx = IDX_C;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stock_manager_if.sv
`default_nettype none
// ============================================================================
// Module : stock_manager_if
// Brief  : Vend/restock bus between vending FSM, operator and stock_manager.
//          SALES_COUNT_EN adds the sales_total signal.
// Rev    : 1.0  initial release
// ============================================================================
interface stock_manager_if #(
    parameter int CNT_W = 3
);
    logic [7:0]       item_code;
    logic             decrement;
    logic             restock_req;
    logic [7:0]       restock_code;
    logic [CNT_W-1:0] restock_qty;
    logic             restock_ack;
    logic [CNT_W-1:0] cs_pc;
    logic [CNT_W-1:0] cs_cb;
    logic [CNT_W-1:0] cs_s;
    logic [CNT_W-1:0] cs_c;
    logic [3:0]       low_stock;
    logic             err;
`ifdef SALES_COUNT_EN
    logic [7:0]       sales_total;
`endif

    modport master (
        output item_code, decrement, restock_req, restock_code, restock_qty,
`ifdef SALES_COUNT_EN
        input  sales_total,
`endif
        input  restock_ack, cs_pc, cs_cb, cs_s, cs_c, low_stock, err
    );

    modport slave (
        input  item_code, decrement, restock_req, restock_code, restock_qty,
`ifdef SALES_COUNT_EN
        output sales_total,
`endif
        output restock_ack, cs_pc, cs_cb, cs_s, cs_c, low_stock, err
    );
endinterface
`default_nettype wire

// File: rtl/stock_manager_slot.sv
`default_nettype none
// ============================================================================
// Module : stock_slot
// Brief  : One stock counter: floor-at-zero vend, then saturating restock add.
// Rev    : 1.0  initial release
// ============================================================================
module stock_slot #(
    parameter int CNT_W      = 3,
    parameter int MAX_STOCK  = 7,
    parameter int INIT_STOCK = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             dec,
    input  wire logic             add_en,
    input  wire logic [CNT_W-1:0] add_qty,
    output logic      [CNT_W-1:0] count,
    output logic                  underflow
);
    logic [CNT_W-1:0] after_dec;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] next_count;

    // A vend on an empty slot is dropped before any restock is added.
    always_comb begin
        underflow  = dec && (count == '0);
        after_dec  = (dec && (count != '0)) ? count - CNT_W'(1) : count;
        sum        = {1'b0, after_dec} + (add_en ? {1'b0, add_qty} : '0);
        next_count = (sum > (CNT_W+1)'(MAX_STOCK)) ? CNT_W'(MAX_STOCK) : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= CNT_W'(INIT_STOCK);
        end else begin
            count <= next_count;
        end
    end
endmodule
`default_nettype wire

// File: rtl/stock_manager.sv
`default_nettype none
// ============================================================================
// Module : stock_manager
// Brief  : Four-slot inventory with vend edge detect, restock handshake FSM,
//          sticky error. SALES_COUNT_EN adds per-slot sold counters/sales_total.
// Rev    : 1.0  initial release
// ============================================================================
module stock_manager
    import stock_manager_pkg::*;
#(
    parameter int CNT_W      = 3,
    parameter int MAX_STOCK  = 7,
    parameter int INIT_STOCK = 5,
    parameter int LOW_THRESH = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    stock_manager_if.slave bus
);
    logic                   dec_q;
    logic                   vend_ev;
    item_dec_t              vend_dec;
    item_dec_t              rs_dec;
    r_state_t               state;
    r_state_t               state_nx;
    logic                   latch;
    logic [7:0]             rs_code;
    logic [CNT_W-1:0]       rs_qty;
    logic [NUM_ITEMS-1:0]   slot_dec;
    logic [NUM_ITEMS-1:0]   slot_add;
    logic [NUM_ITEMS-1:0]   slot_uf;
    logic [CNT_W-1:0]       counts [NUM_ITEMS];
    logic                   err_set;
    logic                   err_q;
`ifdef SALES_COUNT_EN
    logic [7:0]             sold [NUM_ITEMS];
`endif

    always_comb begin
        vend_ev  = bus.decrement & ~dec_q;
        vend_dec = decode_item(bus.item_code);
        rs_dec   = decode_item(rs_code);
        slot_dec = '0;
        slot_add = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            slot_dec[i] = vend_ev && vend_dec.valid && (int'(vend_dec.idx) == i);
            slot_add[i] = (state == R_APPLY) && rs_dec.valid && (int'(rs_dec.idx) == i);
        end
        err_set = (vend_ev && !vend_dec.valid) || (|slot_uf)
                || ((state == R_APPLY) && !rs_dec.valid);
    end

    always_comb begin
        state_nx        = state;
        latch           = 1'b0;
        bus.restock_ack = 1'b0;
        case (state)
            R_IDLE: begin
                if (bus.restock_req) begin
                    latch    = 1'b1;
                    state_nx = R_APPLY;
                end
            end
            R_APPLY: state_nx = R_ACK;
            R_ACK: begin
                bus.restock_ack = 1'b1;
                state_nx        = R_WAIT;
            end
            // Requester still holds req after the ack; wait so it is not re-applied.
            R_WAIT: begin
                if (!bus.restock_req) state_nx = R_IDLE;
            end
            default: state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= R_IDLE;
            dec_q   <= 1'b0;
            rs_code <= '0;
            rs_qty  <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            dec_q <= bus.decrement;
            if (latch) begin
                rs_code <= bus.restock_code;
                rs_qty  <= bus.restock_qty;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
        stock_slot #(
            .CNT_W      (CNT_W),
            .MAX_STOCK  (MAX_STOCK),
            .INIT_STOCK (INIT_STOCK)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .dec       (slot_dec[i]),
            .add_en    (slot_add[i]),
            .add_qty   (rs_qty),
            .count     (counts[i]),
            .underflow (slot_uf[i])
        );
`ifdef SALES_COUNT_EN
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sold[i] <= '0;
            end else if (slot_dec[i] && !slot_uf[i]) begin
                sold[i] <= sold[i] + 8'd1;
            end
        end
`endif
    end

    always_comb begin
        bus.low_stock = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            bus.low_stock[i] = (counts[i] <= CNT_W'(LOW_THRESH));
        end
    end

    assign bus.cs_pc = counts[0];
    assign bus.cs_cb = counts[1];
    assign bus.cs_s  = counts[2];
    assign bus.cs_c  = counts[3];
    assign bus.err   = err_q;
`ifdef SALES_COUNT_EN
    // Modulo-256 sum of the wrapping per-slot counters equals the wrapping total.
    assign bus.sales_total = sold[0] + sold[1] + sold[2] + sold[3];
`endif
endmodule
`default_nettype wire
